// File: rtl/npu_pkg.sv
// Shared NPU types: fp16 storage word, dot-sequencer FSM states and multiplier
// issue spacing.
package npu_pkg;

   typedef logic [15:0] fp16_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      RDWAIT,
      ISSUE,
      MWAIT,
      EMIT,
      FIN
   } seq_state_t;

   // Minimum number of low cycles on mul_start between two multiplier operations.
   localparam int MUL_IDLE_GAP = 1;

endpackage

// File: rtl/fp16_dot_sequencer.sv
// Walks one neuron's input/weight vectors through a single fp16 multiplier and
// streams the products to the accumulator. Optional MWAIT watchdog: SEQ_TIMEOUT_EN.
module fp16_dot_sequencer
   import npu_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int MAX_LEN = 784
`ifdef SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 64
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_start,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [ADDR_W-1:0] cmd_len,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  fp16_t             rd_in_data,
   input  fp16_t             rd_wt_data,
   output fp16_t             mul_a,
   output fp16_t             mul_b,
   output logic              mul_start,
   input  logic              mul_valid,
   input  fp16_t             mul_result,
   output logic              prod_valid,
   input  logic              prod_ready,
   output fp16_t             prod_data,
   output logic              prod_last,
   output logic              err_timeout,
   output seq_state_t        state_dbg
);

   localparam logic [ADDR_W-1:0] MAX_LEN_W = ADDR_W'(MAX_LEN);
   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] base_q, len_q, idx_q, len_clamp;
   logic              accept, is_last, wd_expire;

   // A new job is taken whenever busy is low, which includes the FIN cycle.
   assign len_clamp = (cmd_len > MAX_LEN_W) ? MAX_LEN_W : cmd_len;
   assign accept    = cmd_start && ((state_q == IDLE) || (state_q == FIN));
   assign is_last   = (idx_q == len_q - ONE);
   assign rd_addr   = base_q + idx_q;
   assign state_dbg = state_q;

   // prod_valid/prod_ready: a beat transfers on a clock edge where both are high;
   // once prod_valid rises, prod_data and prod_last stay frozen until that edge.
   always_comb begin
      state_d    = state_q;
      busy       = 1'b0;
      done       = 1'b0;
      rd_en      = 1'b0;
      mul_start  = 1'b0;
      prod_valid = 1'b0;
      prod_last  = 1'b0;
      case (state_q)
         IDLE, FIN: begin
            done = (state_q == FIN);
            if (accept) state_d = (len_clamp == '0) ? FIN : FETCH;
            else        state_d = IDLE;
         end
         FETCH: begin
            busy    = 1'b1;
            rd_en   = 1'b1;
            state_d = RDWAIT;
         end
         RDWAIT: begin
            busy    = 1'b1;
            state_d = ISSUE;
         end
         ISSUE: begin
            busy      = 1'b1;
            mul_start = 1'b1;
            state_d   = MWAIT;
         end
         MWAIT: begin
            busy      = 1'b1;
            mul_start = 1'b1;
            if (mul_valid)      state_d = EMIT;
            else if (wd_expire) state_d = FIN;
         end
         EMIT: begin
            busy       = 1'b1;
            prod_valid = 1'b1;
            prod_last  = is_last;
            if (prod_ready) state_d = is_last ? FIN : FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         base_q    <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         prod_data <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            base_q <= cmd_base;
            len_q  <= len_clamp;
            idx_q  <= '0;
         end
         if (state_q == RDWAIT) begin
            mul_a <= rd_in_data;
            mul_b <= rd_wt_data;
         end
         if ((state_q == MWAIT) && mul_valid) prod_data <= mul_result;
         if ((state_q == EMIT) && prod_ready && !is_last) idx_q <= idx_q + ONE;
      end
   end

`ifdef SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wd_cnt_q;
   logic            err_q;

   // Expires on the TIMEOUT_CYC-th MWAIT cycle that still has no result.
   assign wd_expire   = (state_q == MWAIT) && !mul_valid &&
                        (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));
   assign err_timeout = err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wd_cnt_q <= (state_q == MWAIT) ? wd_cnt_q + 1'b1 : '0;
         if (accept)         err_q <= 1'b0;
         else if (wd_expire) err_q <= 1'b1;
      end
   end
`else
   assign wd_expire   = 1'b0;
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fp16_dot_sequencer.sv
// Bench for fp16_dot_sequencer: RAM and multiplier stand-ins driven at negedge,
// reference products computed per job from the RAM contents and address order.
module tb_fp16_dot_sequencer;
   import npu_pkg::*;

   localparam int ADDR_W  = 10;
   localparam int DEPTH   = 1 << ADDR_W;
   localparam int MAX_LEN = 784;

   logic              clk = 1'b0;
   logic              reset;
   logic              cmd_start;
   logic [ADDR_W-1:0] cmd_base, cmd_len;
   logic              busy, done, rd_en;
   logic [ADDR_W-1:0] rd_addr;
   fp16_t             rd_in_data, rd_wt_data, mul_a, mul_b, mul_result, prod_data;
   logic              mul_start, mul_valid, prod_valid, prod_ready, prod_last, err_timeout;
   seq_state_t        state_dbg;

   fp16_dot_sequencer #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
      .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_base(cmd_base), .cmd_len(cmd_len),
      .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_in_data(rd_in_data), .rd_wt_data(rd_wt_data),
      .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_valid(mul_valid),
      .mul_result(mul_result), .prod_valid(prod_valid), .prod_ready(prod_ready),
      .prod_data(prod_data), .prod_last(prod_last), .err_timeout(err_timeout),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // ---------------- clock/reset, counters, reference state ----------------
   int n_cmp = 0;
   int n_err = 0;

   fp16_t             in_ram [DEPTH];
   fp16_t             wt_ram [DEPTH];
   logic [15:0]       exp_q[$];
   logic [ADDR_W-1:0] exp_addr_q[$];

   int ready_mode = 0;
   bit mul_stall  = 0;
   int stall_left = 0;
   bit stall_done = 0;
   int job_len = 0, beats = 0, last_cnt = 0, done_cnt = 0, rd_cnt = 0, mstart_cnt = 0;
   int pv_cnt = 0, hi_cnt = 0, busy_cnt = 0, sum_lat = 0, rd_stall_cnt = 0;

   bit                rd_pend = 0;
   logic [ADDR_W-1:0] rd_pend_addr = '0;
   bit                m_pend = 0, m_prev = 0, m_seen = 0;
   int                m_cnt = 0, low_run = 0;
   fp16_t             m_a = '0, m_b = '0;
   bit                held = 0;
   fp16_t             held_data = '0;
   logic              held_last = 1'b0;

   // Arbitrary fixed function standing in for the fp16 multiplier.
   function automatic logic [15:0] mul_fn(input logic [15:0] a, input logic [15:0] b);
      return (a ^ {b[7:0], b[15:8]}) + 16'h3c01;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // ---------------- agents: RAM, multiplier, accumulator, scoreboard ----------------
   initial begin
      rd_in_data = '0;
      rd_wt_data = '0;
      mul_valid  = 1'b0;
      mul_result = '0;
      prod_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (rd_pend) begin
            rd_in_data = in_ram[rd_pend_addr];
            rd_wt_data = wt_ram[rd_pend_addr];
         end else begin
            rd_in_data = 16'($urandom);
            rd_wt_data = 16'($urandom);
         end
         rd_pend      = rd_en;
         rd_pend_addr = rd_addr;
         if (rd_en) begin
            rd_cnt++;
            if (exp_addr_q.size() > 0) chk("rd_addr", 32'(rd_addr), 32'(exp_addr_q.pop_front()));
            else                       chk("rd_extra", 32'(rd_en), 32'(0));
         end
         if (busy) busy_cnt++;
         if (mul_start) hi_cnt++;

         mul_valid  = 1'b0;
         mul_result = 16'($urandom);
         if (!mul_start) begin
            m_pend = 0;
            low_run++;
            if ($urandom_range(0, 3) == 0) mul_valid = 1'b1;
         end else if (!m_prev) begin
            mstart_cnt++;
            if (m_seen) chk("mul_gap", 32'(low_run >= MUL_IDLE_GAP), 32'(1));
            m_seen  = 1;
            low_run = 0;
            m_pend  = 1;
            m_cnt   = $urandom_range(1, 4);
            sum_lat += m_cnt;
            m_a     = mul_a;
            m_b     = mul_b;
         end else if (m_pend) begin
            chk("mul_a_hold", 32'(mul_a), 32'(m_a));
            chk("mul_b_hold", 32'(mul_b), 32'(m_b));
            m_cnt--;
            if (m_cnt == 0 && !mul_stall) begin
               mul_valid  = 1'b1;
               mul_result = mul_fn(m_a, m_b);
               m_pend     = 0;
            end
         end else begin
            chk("mul_start_drop", 32'(mul_start), 32'(0));
         end
         m_prev = mul_start;

         case (ready_mode)
            0: prod_ready = 1'b1;
            1: prod_ready = ($urandom_range(0, 2) != 0);
            default: begin
               if (stall_left > 0) begin
                  prod_ready = 1'b0;
                  stall_left--;
               end else if (prod_valid && beats == 1 && !stall_done) begin
                  prod_ready = 1'b0;
                  stall_left = 9;
                  stall_done = 1;
               end else begin
                  prod_ready = 1'b1;
               end
            end
         endcase
         if (rd_en && !prod_ready && ready_mode == 2) rd_stall_cnt++;

         if (prod_valid) begin
            pv_cnt++;
            if (held) begin
               chk("prod_data_hold", 32'(prod_data), 32'(held_data));
               chk("prod_last_hold", 32'(prod_last), 32'(held_last));
            end
            if (prod_ready) begin
               beats++;
               if (exp_q.size() > 0) chk("prod_data", 32'(prod_data), 32'(exp_q.pop_front()));
               else                  chk("prod_extra", 32'(prod_valid), 32'(0));
               chk("prod_last", 32'(prod_last), 32'(beats == job_len));
               if (prod_last) last_cnt++;
               held = 0;
            end else begin
               held      = 1;
               held_data = prod_data;
               held_last = prod_last;
            end
         end else begin
            held = 0;
         end
         if (done) begin
            done_cnt++;
            chk("busy_at_done", 32'(busy), 32'(0));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_model(input int base, input int len);
      int eff;
      eff = (len > MAX_LEN) ? MAX_LEN : len;
      exp_q.delete();
      exp_addr_q.delete();
      for (int i = 0; i < eff; i++) begin
         int a;
         a = (base + i) % DEPTH;
         exp_addr_q.push_back(ADDR_W'(a));
         exp_q.push_back(mul_fn(in_ram[a], wt_ram[a]));
      end
      job_len = eff; beats = 0; last_cnt = 0; done_cnt = 0; rd_cnt = 0; mstart_cnt = 0;
      pv_cnt = 0; hi_cnt = 0; busy_cnt = 0; sum_lat = 0; rd_stall_cnt = 0;
      stall_left = 0; stall_done = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},        32'(busy),        32'(0));
      chk({tag, "_done"},        32'(done),        32'(0));
      chk({tag, "_rd_en"},       32'(rd_en),       32'(0));
      chk({tag, "_mul_start"},   32'(mul_start),   32'(0));
      chk({tag, "_prod_valid"},  32'(prod_valid),  32'(0));
      chk({tag, "_prod_last"},   32'(prod_last),   32'(0));
      chk({tag, "_err_timeout"}, 32'(err_timeout), 32'(0));
      chk({tag, "_rd_addr"},     32'(rd_addr),     32'(0));
      chk({tag, "_mul_a"},       32'(mul_a),       32'(0));
      chk({tag, "_mul_b"},       32'(mul_b),       32'(0));
      chk({tag, "_prod_data"},   32'(prod_data),   32'(0));
   endtask

   task automatic run_job(input int base, input int len, input bit poke);
      int eff, cyc, budget;
      eff = (len > MAX_LEN) ? MAX_LEN : len;
      load_model(base, len);
      cmd_base  = ADDR_W'(base);
      cmd_len   = ADDR_W'(len);
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      chk("err_clear", 32'(err_timeout), 32'(0));
      if (eff == 0) chk("empty_done", 32'(done), 32'(1));
      else          chk("busy_set", 32'(busy), 32'(1));
      if (poke) begin
         repeat (4) @(negedge clk);
         chk("busy_mid", 32'(busy), 32'(1));
         cmd_base  = ADDR_W'($urandom);
         cmd_len   = ADDR_W'($urandom_range(0, 50));
         cmd_start = 1'b1;
         @(negedge clk);
         cmd_start = 1'b0;
      end
      cyc    = 0;
      budget = 40 * eff + 100;
      while (done_cnt == 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      repeat (3) @(negedge clk);
      chk("job_done_cnt", 32'(done_cnt), 32'(1));
      chk("job_beats", 32'(beats), 32'(eff));
      chk("job_last_cnt", 32'(last_cnt), 32'(eff > 0));
      chk("job_exp_left", 32'(exp_q.size()), 32'(0));
      chk("job_rd_cnt", 32'(rd_cnt), 32'(eff));
      chk("job_mul_starts", 32'(mstart_cnt), 32'(eff));
      chk("job_busy_after", 32'(busy), 32'(0));
      if (ready_mode == 0) begin
         chk("job_valid_cycles", 32'(pv_cnt), 32'(eff));
         chk("job_busy_cycles", 32'(busy_cnt), 32'(4 * eff + sum_lat));
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int run, cyc;
      for (int i = 0; i < DEPTH; i++) begin
         in_ram[i] = 16'($urandom);
         wt_ram[i] = 16'($urandom);
      end
      reset     = 1'b1;
      cmd_start = 1'b0;
      cmd_base  = '0;
      cmd_len   = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clk);

      run_job(0, 0, 0);
      run_job(0, 784, 0);

      ready_mode = 2;
      run_job(16, 4, 0);
      chk("bp_valid_cycles", 32'(pv_cnt), 32'(14));
      chk("bp_rd_in_stall", 32'(rd_stall_cnt), 32'(0));

      ready_mode = 0;
      run_job(1020, 8, 0);
      run_job(100, 1000, 0);

      ready_mode = 1;
      for (int j = 0; j < 4; j++) run_job($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), 1);

      // Reset while the multiplier is held off in MWAIT.
      ready_mode = 0;
      mul_stall  = 1;
      load_model(200, 20);
      cmd_base   = ADDR_W'(200);
      cmd_len    = ADDR_W'(20);
      cmd_start  = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      run = 0;
      cyc = 0;
      while (run < 2 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         run = mul_start ? run + 1 : 0;
      end
      chk("rst_reach_mwait", 32'(run), 32'(2));
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_mid");
      reset     = 1'b0;
      mul_stall = 0;
      load_model(0, 0);
      repeat (5) @(negedge clk);
      chk("rst_no_done", 32'(done_cnt), 32'(0));
      run_job(300, 6, 0);

`ifdef SEQ_TIMEOUT_EN
      mul_stall = 1;
      load_model(40, 3);
      cmd_base  = ADDR_W'(40);
      cmd_len   = ADDR_W'(3);
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      cyc = 0;
      while (done_cnt == 0 && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      repeat (3) @(negedge clk);
      chk("to_done_cnt", 32'(done_cnt), 32'(1));
      chk("to_err", 32'(err_timeout), 32'(1));
      chk("to_beats", 32'(beats), 32'(0));
      chk("to_mul_high", 32'(hi_cnt), 32'(65));
      chk("to_rd_cnt", 32'(rd_cnt), 32'(1));
      mul_stall = 0;
      run_job(40, 3, 0);
`endif

      // ---------------- final report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
